// File: rtl/resp_fifo_writer_pkg.sv
// Shared definitions for the response-path FIFO writer: state encoding and
// the data-width defaults also used by the controller and TX FIFO.
package resp_fifo_writer_pkg;

  localparam int FRAME_WIDTH_DEF    = 8;
  localparam int ALU_DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SEND_A = 2'b01,
    SEND_B = 2'b10,
    SEND_R = 2'b11
  } state_e;

endpackage

// File: rtl/resp_fifo_writer_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; once it reaches
// all-ones it sticks there until reset.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rstN_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !(&count_q)) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstN_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/resp_fifo_writer.sv
// Captures ALU results or register reads, serialises them into bytes for the
// TX async FIFO write port, and counts responses that arrive while busy.
module resp_fifo_writer
  import resp_fifo_writer_pkg::*;
#(
  parameter int FRAME_WIDTH    = FRAME_WIDTH_DEF,
  parameter int ALU_DATA_WIDTH = ALU_DATA_WIDTH_DEF,
  parameter bit LSB_FIRST      = 1'b1,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [ALU_DATA_WIDTH-1:0] ALU_OUT,
  input  logic                      OUT_VALID,
  input  logic [FRAME_WIDTH-1:0]    RdData,
  input  logic                      RdData_Valid,
  input  logic                      FIFO_FULL,
  output logic [FRAME_WIDTH-1:0]    WR_DATA,
  output logic                      WR_INC,
  output logic                      BUSY,
  output logic                      DROP,
  output logic [DROP_CNT_WIDTH-1:0] DROP_CNT
);

  state_e                    state_q, state_d;
  logic [ALU_DATA_WIDTH-1:0] data_q, data_d;
  logic                      drop_q, drop_d;
  logic                      finalWrite;
  logic                      accept;
  logic [FRAME_WIDTH-1:0]    lowByte;
  logic [FRAME_WIDTH-1:0]    highByte;

  assign lowByte  = data_q[FRAME_WIDTH-1:0];
  assign highByte = data_q[ALU_DATA_WIDTH-1:FRAME_WIDTH];

  assign BUSY       = (state_q != IDLE);
  assign WR_INC     = BUSY && !FIFO_FULL;
  assign finalWrite = WR_INC && ((state_q == SEND_B) || (state_q == SEND_R));
  assign accept     = (state_q == IDLE) || finalWrite;

  always_comb begin
    WR_DATA = '0;
    case (state_q)
      SEND_A:  WR_DATA = LSB_FIRST ? lowByte : highByte;
      SEND_B:  WR_DATA = LSB_FIRST ? highByte : lowByte;
      SEND_R:  WR_DATA = lowByte;
      default: WR_DATA = '0;
    endcase
  end

  // A new response may only be taken in IDLE or on the last byte's write;
  // anything else that shows up is dropped, at most one count per cycle.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    drop_d  = 1'b0;
    if (accept) begin
      if (OUT_VALID) begin
        state_d = SEND_A;
        data_d  = ALU_OUT;
        drop_d  = RdData_Valid;
      end else if (RdData_Valid) begin
        state_d = SEND_R;
        data_d  = {{(ALU_DATA_WIDTH-FRAME_WIDTH){1'b0}}, RdData};
      end else if (finalWrite) begin
        state_d = IDLE;
      end
    end else begin
      drop_d = OUT_VALID || RdData_Valid;
      if (WR_INC && (state_q == SEND_A)) begin
        state_d = SEND_B;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign DROP = drop_q;

  sat_counter #(
    .WIDTH(DROP_CNT_WIDTH)
  ) uDropCnt (
    .clk_i  (CLK),
    .rstN_i (RST),
    .inc_i  (drop_d),
    .count_o(DROP_CNT)
  );

endmodule

// File: tb/tb_resp_fifo_writer.sv
// Randomised and directed bench for resp_fifo_writer, compared cycle by cycle
// against a byte-queue model of the response path.
module tb_resp_fifo_writer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] ALU_OUT;
  logic        OUT_VALID;
  logic [7:0]  RdData;
  logic        RdData_Valid;
  logic        FIFO_FULL;
  logic [7:0]  WR_DATA;
  logic        WR_INC;
  logic        BUSY;
  logic        DROP;
  logic [7:0]  DROP_CNT;

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0] mBytes[$];
  logic       mDrop;
  int         mCnt;

  resp_fifo_writer dut (
    .CLK         (CLK),
    .RST         (RST),
    .ALU_OUT     (ALU_OUT),
    .OUT_VALID   (OUT_VALID),
    .RdData      (RdData),
    .RdData_Valid(RdData_Valid),
    .FIFO_FULL   (FIFO_FULL),
    .WR_DATA     (WR_DATA),
    .WR_INC      (WR_INC),
    .BUSY        (BUSY),
    .DROP        (DROP),
    .DROP_CNT    (DROP_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // The model holds the bytes still owed to the FIFO for the current
  // response; a new response is accepted when nothing (or only the byte
  // being written this cycle) remains.
  task automatic modelEdge(input logic rst, input logic full, input logic ov,
                           input logic [15:0] alu, input logic rv, input logic [7:0] rd);
    bit busy, inc, acc, drop;
    if (!rst) begin
      mBytes.delete();
      mDrop = 1'b0;
      mCnt  = 0;
      return;
    end
    busy = (mBytes.size() > 0);
    inc  = busy && !full;
    acc  = !busy || (inc && mBytes.size() == 1);
    if (inc) void'(mBytes.pop_front());
    drop = 1'b0;
    if (acc) begin
      if (ov) begin
        mBytes.push_back(alu[7:0]);
        mBytes.push_back(alu[15:8]);
        drop = rv;
      end else if (rv) begin
        mBytes.push_back(rd);
      end
    end else begin
      drop = ov || rv;
    end
    mDrop = drop;
    if (drop && mCnt < 255) mCnt++;
  endtask

  task automatic applyStimulus(input logic rst, input logic full, input logic ov,
                               input logic [15:0] alu, input logic rv, input logic [7:0] rd);
    bit expBusy;
    #1;
    RST = rst; FIFO_FULL = full; OUT_VALID = ov; ALU_OUT = alu;
    RdData_Valid = rv; RdData = rd;
    @(negedge CLK);
    expBusy = (mBytes.size() > 0);
    checkOutput("BUSY", 32'(BUSY), 32'(expBusy));
    checkOutput("WR_INC", 32'(WR_INC), 32'(expBusy && !full));
    checkOutput("WR_DATA", 32'(WR_DATA), expBusy ? 32'(mBytes[0]) : 32'd0);
    checkOutput("DROP", 32'(DROP), 32'(mDrop));
    checkOutput("DROP_CNT", 32'(DROP_CNT), 32'(mCnt));
    @(posedge CLK);
    modelEdge(rst, full, ov, alu, rv, rd);
  endtask

  task automatic idleCycles(input int n, input logic full);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, full, 1'b0, 16'h0, 1'b0, 8'h0);
  endtask

  initial begin
    RST = 1'b0; FIFO_FULL = 1'b0; OUT_VALID = 1'b0; ALU_OUT = '0;
    RdData_Valid = 1'b0; RdData = '0;
    mDrop = 1'b0; mCnt = 0;
    repeat (2) @(posedge CLK);

    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 8'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hA55A, 1'b0, 8'h0);
    idleCycles(3, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 8'h3C);
    idleCycles(2, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 8'h0);
    idleCycles(5, 1'b1);
    idleCycles(3, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b1, 16'h00FF, 1'b1, 8'h77);
    idleCycles(3, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b0, 8'h0);
    idleCycles(1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 8'h11);
    idleCycles(2, 1'b0);

    // Park an ALU response in its second byte, then reset under FIFO_FULL.
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 8'h0);
    idleCycles(1, 1'b0);
    idleCycles(2, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 8'h0);
    idleCycles(3, 1'b0);
    checkOutput("reset_drops_pending", 32'(BUSY), 32'd0);

    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 8'(i));
    checkOutput("drop_saturated", 32'(DROP_CNT), 32'hFF);
    idleCycles(2, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 8'h0);
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) != 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 4) == 0), 16'($urandom),
                    ($urandom_range(0, 4) == 0), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
